div_sched_ctrl: RTL and testbench

Run-time controller for the team's counter-based clock divider. It sequences start, stop and divide-ratio changes, and generates the divided timing as a single-clock enable pulse plus a phase flag, so downstream logic stays on clk rather than on a derived clock. Ratio updates arrive through a valid/ready handshake and take effect only on a period boundary, so no truncated or stretched period is ever produced.

---
 rtl/div_sched_ctrl.sv | 173 +++++++++++++++++
 tb/tb_div_sched_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/div_sched_ctrl.sv
// Run-time controller for the counter-based clock divider: start/stop sequencing,
// period-aligned ratio updates over valid/ready, and a registered enable/phase output.
module div_sched_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4,
  parameter int PCNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_vld,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_rdy,
  output logic              cfg_err,
  output logic              div_en,
  output logic              div_phase,
  output logic [PCNT_W-1:0] po_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  DEF_DIV_C = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  ZERO_C    = {CNT_W{1'b0}};
  localparam logic [PCNT_W-1:0] PO_ONE_C  = PCNT_W'(1);

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [CNT_W-1:0]   cur_div_r, cur_div_s;
  logic [CNT_W-1:0]   pend_div_r, pend_div_s;
  logic               pend_r, pend_s;
  logic               xfer_s, legal_s, tc_s, active_s;
  logic [CNT_W-1:0]   cnt_inc_s;

  logic               cfg_rdy_r, cfg_err_r, div_en_r, div_phase_r, busy_r;
  logic [PCNT_W-1:0]  po_cnt_r;

  // Next-state, counter and ratio bookkeeping; outputs are later registered from these values.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    cur_div_s  = cur_div_r;
    pend_s     = pend_r;
    pend_div_s = pend_div_r;
    xfer_s     = cfg_vld && cfg_rdy_r;
    legal_s    = (cfg_div > ONE_C);
    tc_s       = (cnt_r == (cur_div_r - ONE_C));
    cnt_inc_s  = tc_s ? ZERO_C : (cnt_r + ONE_C);

    case (state_r)
      IDLE: begin
        cnt_s = ZERO_C;
        if (xfer_s && legal_s) begin
          cur_div_s = cfg_div;
        end else begin
          cur_div_s = cur_div_r;
        end
        state_s = en ? RUN : IDLE;
      end
      RUN: begin
        cnt_s = cnt_inc_s;
        if (xfer_s && legal_s) begin
          pend_s     = 1'b1;
          pend_div_s = cfg_div;
        end else begin
          pend_s = pend_r;
        end
        if (!en) begin
          state_s = STOP;
        end else if (xfer_s && legal_s) begin
          state_s = PEND;
        end else begin
          state_s = RUN;
        end
      end
      PEND: begin
        cnt_s = cnt_inc_s;
        if (tc_s) begin
          cur_div_s = pend_div_r;
          pend_s    = 1'b0;
          state_s   = en ? RUN : STOP;
        end else if (!en) begin
          state_s = STOP;
        end else begin
          state_s = PEND;
        end
      end
      STOP: begin
        cnt_s = cnt_inc_s;
        if (tc_s) begin
          // Period boundary: any ratio waiting (or arriving now) becomes current.
          if (pend_r) begin
            cur_div_s = pend_div_r;
            pend_s    = 1'b0;
          end else if (xfer_s && legal_s) begin
            cur_div_s = cfg_div;
          end else begin
            cur_div_s = cur_div_r;
          end
          state_s = en ? RUN : IDLE;
        end else begin
          if (xfer_s && legal_s) begin
            pend_s     = 1'b1;
            pend_div_s = cfg_div;
          end else begin
            pend_s = pend_r;
          end
          if (en) begin
            state_s = pend_s ? PEND : RUN;
          end else begin
            state_s = STOP;
          end
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = ZERO_C;
      end
    endcase

    active_s = (state_s != IDLE);
  end

  // State, counter and ratio registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= ZERO_C;
      cur_div_r  <= DEF_DIV_C;
      pend_r     <= 1'b0;
      pend_div_r <= DEF_DIV_C;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      cur_div_r  <= cur_div_s;
      pend_r     <= pend_s;
      pend_div_r <= pend_div_s;
    end
  end

  // Output registers, decoded from next-state so each reflects the cycle it is seen in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_rdy_r   <= 1'b1;
      cfg_err_r   <= 1'b0;
      div_en_r    <= 1'b0;
      div_phase_r <= 1'b0;
      busy_r      <= 1'b0;
      po_cnt_r    <= {PCNT_W{1'b0}};
    end else begin
      cfg_rdy_r   <= !pend_s;
      cfg_err_r   <= xfer_s && !legal_s;
      div_en_r    <= active_s && (cnt_s == (cur_div_s - ONE_C));
      div_phase_r <= active_s && (cnt_s >= (cur_div_s >> 1));
      busy_r      <= active_s;
      po_cnt_r    <= ((state_r != IDLE) && tc_s) ? (po_cnt_r + PO_ONE_C) : po_cnt_r;
    end
  end

  assign cfg_rdy   = cfg_rdy_r;
  assign cfg_err   = cfg_err_r;
  assign div_en    = div_en_r;
  assign div_phase = div_phase_r;
  assign po_cnt    = po_cnt_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_div_sched_ctrl.sv
// Directed table-driven bench for div_sched_ctrl (CNT_W=8, DEF_DIV=4, PCNT_W=2).
module tb_div_sched_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cfg_vld;
  logic [7:0] cfg_div;
  logic       cfg_rdy;
  logic       cfg_err;
  logic       div_en;
  logic       div_phase;
  logic [1:0] po_cnt;
  logic       busy;

  int n_total;
  int n_pass;

  typedef struct {
    logic       en;
    logic       vld;
    logic [7:0] div;
    logic [6:0] exp;   // {cfg_rdy, cfg_err, div_en, div_phase, po_cnt[1:0], busy}
  } vec_t;

  vec_t vecs[$];

  div_sched_ctrl #(.CNT_W(8), .DEF_DIV(4), .PCNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_vld   (cfg_vld),
    .cfg_div   (cfg_div),
    .cfg_rdy   (cfg_rdy),
    .cfg_err   (cfg_err),
    .div_en    (div_en),
    .div_phase (div_phase),
    .po_cnt    (po_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {cfg_rdy, cfg_err, div_en, div_phase, po_cnt, busy};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got rdy/err/en/ph/po/busy=%b_%b_%b_%b_%0d_%b want %b_%b_%b_%b_%0d_%b",
               name, act[6], act[5], act[4], act[3], act[2:1], act[0],
               exp[6], exp[5], exp[4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic e, input logic v, input logic [7:0] d,
                     input logic rdy, input logic err, input logic den,
                     input logic ph, input logic [1:0] po, input logic bsy);
    vec_t t;
    t.en  = e;
    t.vld = v;
    t.div = d;
    t.exp = {rdy, err, den, ph, po, bsy};
    vecs.push_back(t);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b0;
    en      = 1'b0;
    cfg_vld = 1'b0;
    cfg_div = 8'd0;

    //   en   vld   div    rdy  err  den  ph   po    busy
    // Start at default ratio 4
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);  // 0  c0
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);  // 1  c1
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);  // 2  c2
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1);  // 3  c3 TC
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);  // 4  c0
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);  // 5  c1
    // Ratio 6 offered at cnt=1, takes effect after current TC
    add(1'b1, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);  // 6  c2 pend
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1);  // 7  c3 TC
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);  // 8  c0 at 6
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);  // 9  c1
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);  // 10 c2
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);  // 11 c3
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);  // 12 c4
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1);  // 13 c5 TC
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1);  // 14 c0
    // Illegal ratio 0 while running
    add(1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1);  // 15 c1 err
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1);  // 16 c2
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1);  // 17 c3
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1);  // 18 c4
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1);  // 19 c5 TC
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);  // 20 c0 po wraps
    // Stop at cnt=0: full period completes, then IDLE
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);  // 21 c1
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);  // 22 c2
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);  // 23 c3
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);  // 24 c4
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1);  // 25 c5 TC
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);  // 26 IDLE
    // IDLE: illegal 1 then legal 5
    add(1'b0, 1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);  // 27 err
    add(1'b0, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);  // 28 load 5
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);  // 29 c0 at 5
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);  // 30 c1
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);  // 31 c2
    // Drop en at cnt=2: two more clocks, then IDLE
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);  // 32 c3
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1);  // 33 c4 TC
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);  // 34 IDLE
    // Second trial: drop at cnt=2, reassert at cnt=3
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);  // 35 c0
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);  // 36 c1
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);  // 37 c2
    add(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1);  // 38 c3 STOP
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1);  // 39 c4 TC
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1);  // 40 c0 no gap
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1);  // 41 c1
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1);  // 42 c2
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1);  // 43 c3
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1);  // 44 c4 TC
    // Ratio 3 offered in TC cycle: one more 5-clock period first
    add(1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);  // 45 c0 pend
    add(1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);  // 46 c1 held
    add(1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);  // 47 c2
    add(1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);  // 48 c3
    add(1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1);  // 49 c4 TC
    add(1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);  // 50 c0 at 3
    add(1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);  // 51 c1 accepted
    add(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1);  // 52 c2 TC
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);  // 53 c0 at 2
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1);  // 54 c1 TC
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1);  // 55 c0
    add(1'b1, 1'b1, 8'd7, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1);  // 56 c1 TC pend
    add(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);  // 57 c0 at 7

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0});
    rst = 1'b1;
    tick();
    check("idle_after_release", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0});

    foreach (vecs[i]) begin
      en      = vecs[i].en;
      cfg_vld = vecs[i].vld;
      cfg_div = vecs[i].div;
      tick();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Reset asserted mid-period with a ratio pending (running at 7)
    en      = 1'b1;
    cfg_vld = 1'b1;
    cfg_div = 8'd9;
    tick();
    check("pend_before_rst", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1});
    cfg_vld = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_mid", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0});
    rst = 1'b1;
    tick();
    check("run_c0_post_rst", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1});
    tick();
    check("run_c1_post_rst", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1});
    tick();
    check("run_c2_post_rst", outs(), {1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1});
    tick();
    check("run_tc_post_rst", outs(), {1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1});
    tick();
    check("run_wrap_post_rst", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
